effect_sequencer: RTL and testbench

Sequencer for the seven-digit display effect engines. It converts raw push-button inputs into the `enable[2:0]` effect select and the `frequency[1:0]` speed code that every effect module consumes. It also provides an auto-play mode that steps through the effects on a timer. It sits between the board keys and the effect instances, and inserts a blanking gap on every effect change so the newly selected effect restarts from its first scroll position.

---
 rtl/effect_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_effect_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/effect_sequencer.sv
// effect_sequencer: debounced push-button front end plus the effect select
// state machine (blank / run / off) with a timed auto-play mode.
module effect_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLANK_CYCLES    = 50_000,
    parameter logic [27:0] AUTO_PERIOD     = 28'd250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_speed,
    input  logic       btn_auto,
    input  logic       btn_pause,
    output logic [2:0] enable,
    output logic [1:0] frequency,
    output logic [1:0] effect_idx,
    output logic       auto_on,
    output logic       effect_start
);

    // Debounce counter is at least 20 bits wide, wider if the limit needs it.
    localparam int DB_NEED = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DBW     = (DB_NEED > 20) ? DB_NEED : 20;
    localparam int BLW     = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [DBW-1:0] DB_LIMIT   = DBW'(DEBOUNCE_CYCLES);
    localparam logic [BLW-1:0] BLANK_LAST = BLW'(BLANK_CYCLES - 1);
    localparam logic [27:0]    AUTO_LAST  = AUTO_PERIOD - 28'd1;

    localparam int NB    = 4;
    localparam int B_MODE  = 0;
    localparam int B_SPEED = 1;
    localparam int B_AUTO  = 2;
    localparam int B_PAUSE = 3;

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] press;

    assign btn_raw = {btn_pause, btn_auto, btn_speed, btn_mode};

    // ------------------------------------------------------------------
    // Button front end: identical synchronizer + debouncer per button.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_btn
            logic           sync1_q;
            logic           sync2_q;
            logic           level_q;
            logic           level_d;
            logic           press_q;
            logic           press_d;
            logic [DBW-1:0] cnt_q;
            logic [DBW-1:0] cnt_d;

            // Count while the synchronized level disagrees with the accepted
            // level; accept it once the count reaches the limit. Only a
            // newly accepted high level produces a press pulse.
            always_comb begin
                cnt_d   = cnt_q;
                level_d = level_q;
                press_d = 1'b0;
                if (sync2_q == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LIMIT) begin
                    cnt_d   = '0;
                    level_d = sync2_q;
                    press_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Synchronizer chain and debounce state registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    level_q <= 1'b0;
                    press_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                    level_q <= level_d;
                    press_q <= press_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign press[gi] = press_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Effect sequencing state machine.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_BLANK = 2'd0,
        S_RUN   = 2'd1,
        S_OFF   = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [BLW-1:0] blank_cnt_q;
    logic [BLW-1:0] blank_cnt_d;
    logic [27:0]    auto_cnt_q;
    logic [27:0]    auto_cnt_d;
    logic [2:0]     enable_q;
    logic [2:0]     enable_d;
    logic [1:0]     freq_q;
    logic [1:0]     freq_d;
    logic [1:0]     idx_q;
    logic [1:0]     idx_d;
    logic [1:0]     idx_next;
    logic           auto_q;
    logic           auto_d;
    logic           start_q;
    logic           start_d;
    logic           auto_expire;

    // Effect index wraps 0 -> 1 -> 2 -> 0; 3 is never produced.
    always_comb begin
        idx_next = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end

    // Next-state logic. Pause wins over mode and auto expiry; speed and
    // auto toggles are applied on top of whatever the state logic did.
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        auto_cnt_d  = auto_cnt_q;
        enable_d    = enable_q;
        freq_d      = freq_q;
        idx_d       = idx_q;
        auto_d      = auto_q;
        start_d     = 1'b0;
        auto_expire = 1'b0;

        case (state_q)
            S_BLANK: begin
                enable_d = 3'b000;
                if (press[B_PAUSE]) begin
                    state_d = S_OFF;
                end else if (press[B_MODE]) begin
                    idx_d       = idx_next;
                    blank_cnt_d = '0;
                end else if (blank_cnt_q == BLANK_LAST) begin
                    state_d     = S_RUN;
                    blank_cnt_d = '0;
                    auto_cnt_d  = '0;
                    enable_d    = 3'b001 << idx_q;
                    start_d     = 1'b1;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                auto_expire = auto_q && (auto_cnt_q == AUTO_LAST);
                if (press[B_PAUSE]) begin
                    state_d    = S_OFF;
                    enable_d   = 3'b000;
                    auto_cnt_d = '0;
                end else if (press[B_MODE] || auto_expire) begin
                    state_d     = S_BLANK;
                    idx_d       = idx_next;
                    blank_cnt_d = '0;
                    auto_cnt_d  = '0;
                    enable_d    = 3'b000;
                end else if (auto_q) begin
                    auto_cnt_d = auto_cnt_q + 28'd1;
                end
            end
            S_OFF: begin
                enable_d   = 3'b000;
                auto_cnt_d = '0;
                if (press[B_PAUSE]) begin
                    state_d     = S_BLANK;
                    blank_cnt_d = '0;
                end else if (press[B_MODE]) begin
                    idx_d = idx_next;
                end
            end
            default: begin
                state_d     = S_BLANK;
                blank_cnt_d = '0;
                enable_d    = 3'b000;
            end
        endcase

        if (press[B_SPEED]) begin
            freq_d = freq_q + 2'd1;
        end
        if (press[B_AUTO]) begin
            auto_d     = ~auto_q;
            auto_cnt_d = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_BLANK;
            blank_cnt_q <= '0;
            auto_cnt_q  <= '0;
            enable_q    <= 3'b000;
            freq_q      <= 2'b00;
            idx_q       <= 2'd0;
            auto_q      <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            auto_cnt_q  <= auto_cnt_d;
            enable_q    <= enable_d;
            freq_q      <= freq_d;
            idx_q       <= idx_d;
            auto_q      <= auto_d;
            start_q     <= start_d;
        end
    end

    assign enable       = enable_q;
    assign frequency    = freq_q;
    assign effect_idx   = idx_q;
    assign auto_on      = auto_q;
    assign effect_start = start_q;

endmodule

// File: tb/tb_effect_sequencer.sv
// tb_effect_sequencer: directed stimulus pushes expected output changes into
// a scoreboard; a monitor pops one entry each time the output tuple changes.
module tb_effect_sequencer;

    localparam int          DB = 4;
    localparam int          BL = 3;
    localparam logic [27:0] AP = 28'd20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_speed = 1'b0;
    logic       btn_auto = 1'b0;
    logic       btn_pause = 1'b0;
    logic [2:0] enable;
    logic [1:0] frequency;
    logic [1:0] effect_idx;
    logic       auto_on;
    logic       effect_start;

    effect_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .BLANK_CYCLES(BL),
        .AUTO_PERIOD(AP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_mode(btn_mode),
        .btn_speed(btn_speed),
        .btn_auto(btn_auto),
        .btn_pause(btn_pause),
        .enable(enable),
        .frequency(frequency),
        .effect_idx(effect_idx),
        .auto_on(auto_on),
        .effect_start(effect_start)
    );

    always #5 clk = ~clk;

    // Expected output change: tuple {enable, frequency, idx, auto_on, start},
    // required gap since the previous change (0 = any) and required absolute
    // cycle (0 = any).
    typedef struct {
        logic [8:0] t;
        int         gap;
        int         at;
    } exp_t;

    exp_t       sb[$];
    string      sb_name[$];
    int         cyc = 0;
    logic       rst_edge = 1'b1;
    int         checks = 0;
    int         passes = 0;
    logic [8:0] prev_obs = 9'd0;
    int         last_chg = 0;

    // Hand-computed vector tables.
    logic [2:0] mode_en  [3] = '{3'b010, 3'b100, 3'b001};
    logic [1:0] mode_idx [3] = '{2'd1, 2'd2, 2'd0};
    logic [1:0] speed_tab[5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};

    // Cycle counter and reset-at-edge tracker.
    initial begin
        forever begin
            @(posedge clk);
            cyc      = cyc + 1;
            rst_edge = rst;
        end
    end

    task automatic check_val(input string nm, input int got, input int req);
        checks++;
        if (got == req) passes++;
        else $display("FAIL %s cyc=%0d got=%0d required=%0d", nm, cyc, got, req);
    endtask

    // Scoreboard monitor.
    initial begin
        logic [8:0] obs;
        exp_t       e;
        string      nm;
        forever begin
            @(negedge clk);
            obs = {enable, frequency, effect_idx, auto_on, effect_start};
            if (rst_edge) begin
                check_val("reset_state", int'(obs), 0);
                prev_obs = obs;
                last_chg = cyc;
            end else if (obs !== prev_obs) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_change cyc=%0d got=%b required=%b", cyc, obs, prev_obs);
                end else begin
                    e  = sb.pop_front();
                    nm = sb_name.pop_front();
                    $display("txn %s cyc=%0d enable=%b freq=%b idx=%0d auto=%b start=%b",
                             nm, cyc, enable, frequency, effect_idx, auto_on, effect_start);
                    check_val({nm, "_outputs"}, int'(obs), int'(e.t));
                    if (e.gap != 0) check_val({nm, "_gap"}, cyc - last_chg, e.gap);
                    if (e.at != 0) check_val({nm, "_cycle"}, cyc, e.at);
                end
                prev_obs = obs;
                last_chg = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string nm, input logic [2:0] en, input logic [1:0] fr,
                            input logic [1:0] idx, input logic au, input logic st,
                            input int gap, input int at);
        exp_t e;
        e.t   = {en, fr, idx, au, st};
        e.gap = gap;
        e.at  = at;
        sb.push_back(e);
        sb_name.push_back(nm);
    endtask

    // Drive button mask {pause, auto, speed, mode} for hold cycles, then idle.
    task automatic hold_release(input logic [3:0] mask, input int hold);
        {btn_pause, btn_auto, btn_speed, btn_mode} = mask;
        repeat (hold) tick();
        {btn_pause, btn_auto, btn_speed, btn_mode} = 4'b0000;
        repeat (12) tick();
    endtask

    task automatic drain(input string nm, input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() == 0) passes++;
        else begin
            $display("FAIL drain_%s pending=%0d required=0", nm, sb.size());
            sb.delete();
            sb_name.delete();
        end
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int c;
        rst = 1'b1;
        repeat (3) tick();

        // Startup: three blank cycles, then effect 1 with a start pulse.
        push_exp("boot_run", 3'b001, 2'b00, 2'd0, 1'b0, 1'b1, 3, 0);
        push_exp("boot_start_end", 3'b001, 2'b00, 2'd0, 1'b0, 1'b0, 1, 0);
        rst = 1'b0;
        drain("boot", 20);
        repeat (5) tick();

        // Mode presses step 1, 2, 0 with a 3-cycle blank each.
        for (int k = 0; k < 3; k++) begin
            tick();
            c = cyc;
            push_exp("mode_blank", 3'b000, 2'b00, mode_idx[k], 1'b0, 1'b0, 0, c + 8);
            push_exp("mode_run", mode_en[k], 2'b00, mode_idx[k], 1'b0, 1'b1, 3, 0);
            push_exp("mode_start_end", mode_en[k], 2'b00, mode_idx[k], 1'b0, 1'b0, 1, 0);
            hold_release(4'b0001, 10);
            drain("mode", 30);
        end

        // Short glitch on mode: nothing may change.
        tick();
        hold_release(4'b0001, 2);
        repeat (10) tick();
        check_val("glitch_idx", int'(effect_idx), 0);
        check_val("glitch_enable", int'(enable), 1);

        // Speed presses: frequency wraps modulo 4, no blanking.
        for (int k = 0; k < 5; k++) begin
            tick();
            c = cyc;
            push_exp("speed", 3'b001, speed_tab[k], 2'd0, 1'b0, 1'b0, 0, c + 8);
            hold_release(4'b0010, 10);
            drain("speed", 30);
        end

        // Auto on: an advance every 20 run cycles.
        tick();
        c = cyc;
        push_exp("auto_on", 3'b001, 2'b01, 2'd0, 1'b1, 1'b0, 0, c + 8);
        push_exp("auto_blank1", 3'b000, 2'b01, 2'd1, 1'b1, 1'b0, 20, 0);
        push_exp("auto_run1", 3'b010, 2'b01, 2'd1, 1'b1, 1'b1, 3, 0);
        push_exp("auto_start_end1", 3'b010, 2'b01, 2'd1, 1'b1, 1'b0, 1, 0);
        push_exp("auto_blank2", 3'b000, 2'b01, 2'd2, 1'b1, 1'b0, 19, 0);
        push_exp("auto_run2", 3'b100, 2'b01, 2'd2, 1'b1, 1'b1, 3, 0);
        push_exp("auto_start_end2", 3'b100, 2'b01, 2'd2, 1'b1, 1'b0, 1, 0);
        push_exp("auto_blank3", 3'b000, 2'b01, 2'd0, 1'b1, 1'b0, 19, 0);
        push_exp("auto_run3", 3'b001, 2'b01, 2'd0, 1'b1, 1'b1, 3, 0);
        push_exp("auto_start_end3", 3'b001, 2'b01, 2'd0, 1'b1, 1'b0, 1, 0);
        hold_release(4'b0100, 10);
        drain("auto", 120);

        // Auto off: no further advances.
        tick();
        c = cyc;
        push_exp("auto_off", 3'b001, 2'b01, 2'd0, 1'b0, 1'b0, 0, c + 8);
        hold_release(4'b0100, 10);
        drain("auto_off", 30);
        repeat (40) tick();
        check_val("auto_idle_enable", int'(enable), 1);

        // Pause and mode together: off, index unchanged.
        tick();
        c = cyc;
        push_exp("pause_off", 3'b000, 2'b01, 2'd0, 1'b0, 1'b0, 0, c + 8);
        hold_release(4'b1001, 10);
        drain("pause", 30);

        // Mode while off: index advances, stays off.
        tick();
        c = cyc;
        push_exp("off_mode", 3'b000, 2'b01, 2'd1, 1'b0, 1'b0, 0, c + 8);
        hold_release(4'b0001, 10);
        drain("off_mode", 30);

        // Pause again: 3 blank cycles then the new effect.
        tick();
        c = cyc;
        push_exp("resume_run", 3'b010, 2'b01, 2'd1, 1'b0, 1'b1, 0, c + 11);
        push_exp("resume_start_end", 3'b010, 2'b01, 2'd1, 1'b0, 1'b0, 1, 0);
        hold_release(4'b1000, 10);
        drain("resume", 30);

        // Speed to 10, then auto + mode together, reset mid-blank.
        tick();
        c = cyc;
        push_exp("speed_10", 3'b010, 2'b10, 2'd1, 1'b0, 1'b0, 0, c + 8);
        hold_release(4'b0010, 10);
        drain("speed_10", 30);

        tick();
        c = cyc;
        push_exp("auto_mode", 3'b000, 2'b10, 2'd2, 1'b1, 1'b0, 0, c + 8);
        push_exp("reboot_run", 3'b001, 2'b00, 2'd0, 1'b0, 1'b1, 3, 0);
        push_exp("reboot_start_end", 3'b001, 2'b00, 2'd0, 1'b0, 1'b0, 1, 0);
        {btn_pause, btn_auto, btn_speed, btn_mode} = 4'b0101;
        repeat (8) tick();
        rst = 1'b1;
        {btn_pause, btn_auto, btn_speed, btn_mode} = 4'b0000;
        repeat (2) tick();
        rst = 1'b0;
        drain("reboot", 30);
        repeat (5) tick();
        check_val("final_auto_on", int'(auto_on), 0);
        check_val("final_frequency", int'(frequency), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
